// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants, state/class enums and operand classification
// for the sequential binary32 adder (fp32_add_seq) and its helpers.
package fp32_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          MANT_W   = 24;  // hidden 1 + 23 fraction bits
  localparam int          EXT_W    = 27;  // mantissa + guard, round, sticky

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND
  } fp_add_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  // Sign-independent class of a binary32 value. Exponent 0 counts as zero
  // regardless of fraction, so subnormals are flushed.
  function automatic fp_class_t classify(input logic [30:0] v);
    fp_class_t c;
    if (v[30:23] == 8'h00) begin
      c = CLS_ZERO;
    end else if (v[30:23] == 8'hFF) begin
      c = (v[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/lzc28.sv
// lzc28: combinational leading-zero counter for a 28-bit word.
//   value : word to scan (bit 27 is the most significant)
//   count : number of zeros above the highest set bit; 28 when value is 0
module lzc28 (
  input  logic [27:0] value,
  input  logic        unused_tie,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/fp32_add_seq.sv
// fp32_add_seq: IEEE-754 binary32 adder/subtractor, fixed 5-cycle latency,
// one operation in flight at a time (IDLE->ALIGN->ADD->NORM->ROUND->IDLE).
//   clk_50m, rst : clock and synchronous active-high reset
//   start        : request, sampled only in IDLE, together with op_a/op_b/sub
//   op_a, op_b   : binary32 operands; sub=1 computes op_a - op_b
//   busy         : operation in flight (includes the done cycle)
//   done         : one-cycle pulse when result/overflow/invalid update
//   result       : packed result, held until the next done
//   overflow     : finite operands rounded to +/-inf
//   invalid      : inf - inf
module fp32_add_seq (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        invalid
);
  import fp32_pkg::*;

  localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

  fp_add_state_t state_q, state_d;

  // Captured operands; b holds the effective sign (op_b[31] ^ sub).
  logic [31:0] a_q, a_d, b_q, b_d;
  fp_class_t   a_cls_q, a_cls_d, b_cls_q, b_cls_d;

  logic               x_sign_q, x_sign_d, eff_sub_q, eff_sub_d;
  logic [7:0]         x_exp_q, x_exp_d;
  logic [EXT_W-1:0]   x_mant_q, x_mant_d, y_mant_q, y_mant_d;
  logic [EXT_W:0]     sum_q, sum_d;
  logic               sum_sign_q, sum_sign_d;
  logic [7:0]         sum_exp_q, sum_exp_d;
  logic               norm_sign_q, norm_sign_d, norm_zero_q, norm_zero_d;
  logic signed [9:0]  norm_exp_q, norm_exp_d;
  logic [EXT_W-1:0]   norm_mant_q, norm_mant_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d, overflow_q, overflow_d, invalid_q, invalid_d;

  logic               swap;
  logic [31:0]        xv, yv;
  fp_class_t          xc, yc;
  logic [EXT_W-1:0]   y_ext, y_sh;
  logic [7:0]         exp_diff;
  logic [4:0]         sh_amt;
  logic               y_lost;
  logic [4:0]         lz_cnt;
  logic [EXT_W:0]     sum_shl;
  logic signed [9:0]  exp_n, exp_r;
  logic [MANT_W:0]    rnd;
  logic [22:0]        frac_r;

  // Round-to-nearest-even on {mantissa, g, r, s}; bit 24 of the return is
  // the carry out of the 24-bit mantissa.
  function automatic logic [MANT_W:0] round_rne(input logic [EXT_W-1:0] m);
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[EXT_W-1:3]} + {{MANT_W{1'b0}}, up};
  endfunction

  lzc28 u_lzc28 (
    .value      (sum_q),
    .unused_tie (1'b0),
    .count      (lz_cnt)
  );

  // Datapath: every stage recomputes from the previous stage's registers;
  // only the operand capture is gated, so each stage is valid one cycle after
  // its predecessor and stays stable until the next accepted start.
  always_comb begin
    // ALIGN: larger magnitude becomes X, Y is shifted right with sticky.
    swap      = (b_q[30:0] > a_q[30:0]);
    xv        = swap ? b_q : a_q;
    yv        = swap ? a_q : b_q;
    xc        = swap ? b_cls_q : a_cls_q;
    yc        = swap ? a_cls_q : b_cls_q;
    x_mant_d  = {xc == CLS_NORM, xv[22:0], 3'b000};
    y_ext     = {yc == CLS_NORM, yv[22:0], 3'b000};
    exp_diff  = xv[30:23] - yv[30:23];
    sh_amt    = (exp_diff >= 8'd27) ? 5'd27 : exp_diff[4:0];
    y_sh      = y_ext >> sh_amt;
    y_lost    = |(y_ext & ~({EXT_W{1'b1}} << sh_amt));
    y_mant_d  = {y_sh[EXT_W-1:1], y_sh[0] | y_lost};
    x_sign_d  = xv[31];
    x_exp_d   = xv[30:23];
    eff_sub_d = a_q[31] ^ b_q[31];

    // ADD: X >= Y in magnitude, so the difference never goes negative.
    sum_d      = eff_sub_q ? ({1'b0, x_mant_q} - {1'b0, y_mant_q})
                           : ({1'b0, x_mant_q} + {1'b0, y_mant_q});
    sum_sign_d = x_sign_q;
    sum_exp_d  = x_exp_q;

    // NORM: shifting by the 28-bit leading-zero count puts the leading 1 at
    // bit 27; that covers the carry case (count 0, exponent +1) and the
    // cancellation case with one formula. Bits below the kept 26 fold into
    // sticky.
    sum_shl     = sum_q << lz_cnt;
    exp_n       = $signed({2'b00, sum_exp_q}) + 10'sd1 - $signed({5'd0, lz_cnt});
    norm_mant_d = {sum_shl[EXT_W:2], |sum_shl[1:0]};
    norm_exp_d  = exp_n;
    norm_sign_d = sum_sign_q;
    norm_zero_d = 1'b0;
    if (sum_q == '0) begin
      norm_zero_d = 1'b1;
      norm_sign_d = 1'b0;
    end else if (exp_n <= 10'sd0) begin
      norm_zero_d = 1'b1;
    end

    // ROUND: a mantissa carry leaves 1.000..., so shifting right is exact.
    rnd    = round_rne(norm_mant_q);
    exp_r  = norm_exp_q + (rnd[MANT_W] ? 10'sd1 : 10'sd0);
    frac_r = rnd[MANT_W] ? rnd[23:1] : rnd[22:0];
  end

  // Control and output registers.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_cls_d    = a_cls_q;
    b_cls_d    = b_cls_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = {op_b[31] ^ sub, op_b[30:0]};
          a_cls_d = classify(op_a[30:0]);
          b_cls_d = classify(op_b[30:0]);
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = ST_ROUND;
      ST_ROUND: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        overflow_d = 1'b0;
        invalid_d  = 1'b0;
        if (a_cls_q == CLS_NAN || b_cls_q == CLS_NAN) begin
          result_d = QNAN;
        end else if (a_cls_q == CLS_INF && b_cls_q == CLS_INF && a_q[31] != b_q[31]) begin
          result_d  = QNAN;
          invalid_d = 1'b1;
        end else if (a_cls_q == CLS_INF) begin
          result_d = {a_q[31], 8'hFF, 23'd0};
        end else if (b_cls_q == CLS_INF) begin
          result_d = {b_q[31], 8'hFF, 23'd0};
        end else if (a_cls_q == CLS_ZERO && b_cls_q == CLS_ZERO && a_q[31] && b_q[31]) begin
          result_d = 32'h8000_0000;
        end else if (norm_zero_q) begin
          result_d = {norm_sign_q, 31'd0};
        end else if (exp_r >= EXP_MAX_S) begin
          result_d   = {norm_sign_q, 8'hFF, 23'd0};
          overflow_d = 1'b1;
        end else begin
          result_d = {norm_sign_q, exp_r[7:0], frac_r};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
    end
  end

  always_ff @(posedge clk_50m) begin
    a_q         <= a_d;
    b_q         <= b_d;
    a_cls_q     <= a_cls_d;
    b_cls_q     <= b_cls_d;
    x_sign_q    <= x_sign_d;
    x_exp_q     <= x_exp_d;
    x_mant_q    <= x_mant_d;
    y_mant_q    <= y_mant_d;
    eff_sub_q   <= eff_sub_d;
    sum_q       <= sum_d;
    sum_sign_q  <= sum_sign_d;
    sum_exp_q   <= sum_exp_d;
    norm_sign_q <= norm_sign_d;
    norm_zero_q <= norm_zero_d;
    norm_exp_q  <= norm_exp_d;
    norm_mant_q <= norm_mant_d;
  end

  // The done cycle already sits in IDLE, so busy covers it explicitly.
  assign busy     = (state_q != ST_IDLE) | done_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule
